// File: rtl/pkt_stream_sched.sv
// pkt_stream_sched: round-robin arbiter over NUM_REQ packet sources feeding one
// AXI4-Stream master. A granted packet is captured into a shadow register and
// streamed LSB-first as NUM beats, with TLAST on the final beat.
module pkt_stream_sched #(
    parameter int unsigned PACKAGE_WIDTH        = 1600,
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned NUM_REQ              = 2,
    parameter int unsigned CNT_WIDTH            = 16
) (
    input  logic                                               clk_i,
    input  logic                                               reset_i,
    input  logic [NUM_REQ-1:0]                                 req_valid_i,
    input  logic [NUM_REQ*PACKAGE_WIDTH-1:0]                   req_data_i,
    output logic [NUM_REQ-1:0]                                 req_ready_o,
    output logic                                               M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]                    M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]                  M_AXIS_TSTRB,
    output logic                                               M_AXIS_TLAST,
    input  logic                                               M_AXIS_TREADY,
    output logic                                               busy_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]   grant_id_o,
    output logic [CNT_WIDTH-1:0]                               pkt_count_o
);

    localparam int unsigned NUM    = PACKAGE_WIDTH / C_M_AXIS_TDATA_WIDTH;
    localparam int unsigned BEAT_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                                         state;
    logic [BEAT_W-1:0]                              beat;
    logic [ID_W-1:0]                                rr_ptr;
    logic [NUM-1:0][C_M_AXIS_TDATA_WIDTH-1:0]       shadow;
    logic [NUM_REQ-1:0][PACKAGE_WIDTH-1:0]          req_pk;
    logic [ID_W-1:0]                                cand;
    logic [ID_W-1:0]                                gnt_idx;
    logic                                           gnt_found;
    logic                                           last_beat;

    // Packed view of the flat packet bus: one PACKAGE_WIDTH slot per requester.
    assign req_pk = req_data_i;

    // Round-robin search: first pending requester starting at rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Output decode from registered state; ready is only offered while IDLE.
    always_comb begin
        last_beat     = (beat == BEAT_W'(NUM - 1));
        req_ready_o   = (state == IDLE && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;
        M_AXIS_TVALID = (state == SEND);
        M_AXIS_TLAST  = (state == SEND) && last_beat;
        M_AXIS_TDATA  = (state == SEND) ? shadow[beat] : '0;
        M_AXIS_TSTRB  = '1;
        busy_o        = (state == SEND);
    end

    // Scheduler FSM: capture on grant, step beats on each accepted transfer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            beat        <= '0;
            rr_ptr      <= '0;
            grant_id_o  <= '0;
            pkt_count_o <= '0;
            shadow      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        shadow     <= req_pk[gnt_idx];
                        grant_id_o <= gnt_idx;
                        rr_ptr     <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        beat       <= '0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (M_AXIS_TREADY) begin
                        if (last_beat) begin
                            // beat is parked at 0 so the IDLE mux never points past the packet
                            beat        <= '0;
                            state       <= IDLE;
                            pkt_count_o <= pkt_count_o + 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_stream_sched.sv
// Scoreboard bench for pkt_stream_sched: requesters post random packets, the
// reference arbiter decides who should win and queues the expected beats; a
// separate monitor compares every presented beat against that queue.
module tb_pkt_stream_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned PW   = 256;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 3;
    localparam int unsigned NUM  = PW / DW;
    localparam int unsigned IDW  = 2;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ*PW-1:0]   req_data_i;
    logic [NREQ-1:0]      req_ready_o;
    logic                 m_tvalid;
    logic [DW-1:0]        m_tdata;
    logic [DW/8-1:0]      m_tstrb;
    logic                 m_tlast;
    logic                 m_tready;
    logic                 busy_o;
    logic [IDW-1:0]       grant_id_o;
    logic [CW-1:0]        pkt_count_o;

    pkt_stream_sched #(
        .PACKAGE_WIDTH        (PW),
        .C_M_AXIS_TDATA_WIDTH (DW),
        .NUM_REQ              (NREQ),
        .CNT_WIDTH            (CW)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TSTRB  (m_tstrb),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready),
        .busy_o        (busy_o),
        .grant_id_o    (grant_id_o),
        .pkt_count_o   (pkt_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        int unsigned   id;
    } beat_t;

    beat_t         exp_q[$];
    logic [PW-1:0] pkt[NREQ];
    bit            pending[NREQ];
    int unsigned   rr;
    int unsigned   exp_cnt;
    bit            idle_now;
    bit            chk_en;
    int            errors;
    int            checks;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [PW-1:0] rand_pkt();
        logic [PW-1:0] p;
        for (int w = 0; w < int'(PW / 32); w++) p[w*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic post(input int unsigned k);
        pending[k] = 1'b1;
        pkt[k]     = rand_pkt();
    endtask

    // One cycle of stimulus; reference arbitration decided at negedge+2,
    // after the monitor has recorded whether the stream was idle this cycle.
    task automatic drive_cycle(input bit gen, input bit trdy);
        int          win;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk_i);
        if (gen) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                if (!pending[k]) begin
                    if ($urandom_range(99) < 30) post(k);
                end else if ($urandom_range(99) < 5) begin
                    pending[k] = 1'b0;
                end
            end
        end
        for (int k = 0; k < int'(NREQ); k++) begin
            req_valid_i[k]          = pending[k];
            req_data_i[k*PW +: PW]  = pkt[k];
        end
        m_tready = trdy;
        #2;
        if (idle_now) begin
            win = -1;
            for (int i = 0; i < int'(NREQ); i++) begin
                if (win < 0 && pending[(rr + i) % NREQ]) win = int'((rr + i) % NREQ);
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready_idle", 64'(req_ready_o), 64'(exp_rdy));
            if (win >= 0) begin
                for (int b = 0; b < int'(NUM); b++) begin
                    beat_t e;
                    e.data = pkt[win][b*DW +: DW];
                    e.last = (b == int'(NUM) - 1);
                    e.id   = win;
                    exp_q.push_back(e);
                end
                rr           = (win + 1) % NREQ;
                pending[win] = 1'b0;
            end
        end else begin
            chk("req_ready_busy", 64'(req_ready_o), 64'(0));
        end
    endtask

    function automatic bit all_done();
        bit any = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) any |= pending[k];
        return !any && exp_q.size() == 0;
    endfunction

    task automatic run_until_idle(input string name, input int max_cycles);
        int n = 0;
        while (!all_done() && n < max_cycles) begin
            drive_cycle(1'b0, 1'b1);
            n++;
        end
        chk({name, "_timeout"}, 64'(all_done()), 64'(1));
    endtask

    // Monitor: stream outputs against the head of the expected-beat queue.
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (chk_en) begin
                idle_now = (exp_q.size() == 0);
                chk("tvalid", 64'(m_tvalid), 64'(!idle_now));
                chk("busy", 64'(busy_o), 64'(!idle_now));
                chk("tstrb", 64'(m_tstrb), 64'({(DW/8){1'b1}}));
                chk("pkt_count", 64'(pkt_count_o), 64'(exp_cnt));
                if (!idle_now) begin
                    chk("tdata", 64'(m_tdata), 64'(exp_q[0].data));
                    chk("tlast", 64'(m_tlast), 64'(exp_q[0].last));
                    chk("grant_id", 64'(grant_id_o), 64'(exp_q[0].id));
                    if (m_tready) begin
                        beat_t b;
                        b = exp_q.pop_front();
                        if (b.last) exp_cnt = (exp_cnt + 1) % (1 << CW);
                    end
                end else begin
                    chk("tlast_idle", 64'(m_tlast), 64'(0));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stall;
        bit stalled;
        errors = 0; checks = 0; rr = 0; exp_cnt = 0;
        idle_now = 1'b1; chk_en = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            pending[k] = 1'b0;
            pkt[k]     = '0;
        end
        reset_i = 1'b1; req_valid_i = '0; req_data_i = '0; m_tready = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_tlast", 64'(m_tlast), 64'(0));
        chk("rst_tdata", 64'(m_tdata), 64'(0));
        chk("rst_ready", 64'(req_ready_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_grant", 64'(grant_id_o), 64'(0));
        chk("rst_count", 64'(pkt_count_o), 64'(0));
        chk("rst_tstrb", 64'(m_tstrb), 64'({(DW/8){1'b1}}));
        #1;
        chk_en = 1'b1;

        // Single packet, then an idle requester skipped (rr=1, only 3 valid),
        // then all four valid: rotation continues from requester 0.
        post(0);
        run_until_idle("single", 100);
        post(3);
        run_until_idle("skip", 100);
        for (int k = 0; k < int'(NREQ); k++) post(k);
        run_until_idle("fair", 200);

        // Backpressure: alternate TREADY with a 5-cycle stall mid-packet.
        post(1);
        n = 0; stall = 0; stalled = 1'b0;
        while (!all_done() && n < 200) begin
            if (!stalled && exp_q.size() == NUM - 4) begin
                stall = 5; stalled = 1'b1;
            end
            if (stall > 0) begin
                stall--;
                drive_cycle(1'b0, 1'b0);
            end else begin
                drive_cycle(1'b0, n[0]);
            end
            n++;
        end
        chk("bp_timeout", 64'(all_done()), 64'(1));

        // Reset mid-packet from requester 1 (rr then points at 2).
        post(1);
        n = 0;
        while (exp_q.size() != NUM - 4 && n < 50) begin
            drive_cycle(1'b0, 1'b1);
            n++;
        end
        chk("rst_mid_reach", 64'(exp_q.size()), 64'(NUM - 4));
        @(negedge clk_i);
        reset_i = 1'b1; m_tready = 1'b0; req_valid_i = '0;
        @(posedge clk_i);
        #1;
        exp_q.delete(); rr = 0; exp_cnt = 0;
        for (int k = 0; k < int'(NREQ); k++) pending[k] = 1'b0;
        reset_i = 1'b0;
        post(0);
        post(2);
        run_until_idle("post_rst", 100);

        // Random traffic with random backpressure and withdrawals.
        for (int i = 0; i < 800; i++) drive_cycle(1'b1, ($urandom_range(99) < 70));
        run_until_idle("drain", 400);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
